operand_fetch: RTL and testbench

Sequencer on the port side of the 2-read/1-write register file. It accepts operand-read requests from decode and writeback requests from the execute/memory stages, and drives the register file's `rd`/`rs1`/`rs2` enables and addresses under that file's access rules: a write blocks reads in the same cycle, and `rs2` is only read together with `rs1`. It captures the registered read data, forwards same-cycle writebacks, and presents both operands to execute on a valid/ready handshake.

---
 rtl/operand_fetch.sv | 142 ++++++++++++++
 tb/tb_operand_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: port-side sequencer for a 2-read/1-write register file.
// Takes one operand request at a time from decode and issues the reads.
// Writebacks pass straight through to the file's write port. A writeback that
// lands while the read data is being captured is forwarded into the operands.
// The operands are then held for execute until execute accepts them.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// On the request side, req_ready is high only in IDLE, so one request is in
// flight at a time. On the operand side, once op_valid rises the operands and
// op_valid hold steady until op_ready is seen high at an edge. Writebacks have
// no ready signal and are always taken.
module operand_fetch #(
  parameter int reg_width  = 5,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [reg_width-1:0]  req_rs1,
  input  logic [reg_width-1:0]  req_rs2,
  input  logic                  req_rs1_use,
  input  logic                  req_rs2_use,
  input  logic                  wb_valid,
  input  logic [reg_width-1:0]  wb_rd,
  input  logic [data_width-1:0] wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [data_width-1:0] op_rs1_data,
  output logic [data_width-1:0] op_rs2_data,
  output logic                  rf_rd_en,
  output logic                  rf_rs1_en,
  output logic                  rf_rs2_en,
  output logic [reg_width-1:0]  rf_rd,
  output logic [reg_width-1:0]  rf_rs1,
  output logic [reg_width-1:0]  rf_rs2,
  output logic [data_width-1:0] rf_rd_din,
  input  logic [data_width-1:0] rf_rs1_dout,
  input  logic [data_width-1:0] rf_rs2_dout,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t                state_q;
  logic [reg_width-1:0]  rs1_q, rs2_q;
  logic                  rs1_use_q, rs2_use_q;
  logic                  op_valid_q;
  logic [data_width-1:0] op_rs1_q, op_rs2_q;
  logic [data_width-1:0] op_rs1_d, op_rs2_d;
  logic                  accept;
  logic                  issue_read;

  assign dbg_state   = state_q;
  assign op_valid    = op_valid_q;
  assign op_rs1_data = op_rs1_q;
  assign op_rs2_data = op_rs2_q;

  // The write port is a pure pass-through. x0 writes go through unchanged,
  // and the file itself decides what to do with them.
  assign rf_rd_en  = wb_valid && rst_n;
  assign rf_rd     = wb_rd;
  assign rf_rd_din = wb_data;

  // Read addresses come from the latched request, so they stay stable
  // from ISSUE through WAIT.
  assign rf_rs1 = rs1_q;
  assign rf_rs2 = rs2_q;

  assign req_ready = rst_n && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // A write in the same cycle owns the file ports, so the reads wait for it.
  // The file ignores rs2_en unless rs1_en is also set, so an rs2-only request
  // still raises rs1_en.
  assign issue_read = rst_n && (state_q == S_ISSUE) && !wb_valid;
  assign rf_rs1_en  = issue_read && (rs1_use_q || rs2_use_q);
  assign rf_rs2_en  = issue_read && rs2_use_q;

  // Capture values for WAIT: an unused operand is 0; a writeback to the
  // same non-zero register in this cycle overrides the file's read data.
  always_comb begin
    op_rs1_d = '0;
    op_rs2_d = '0;
    if (rs1_use_q) begin
      op_rs1_d = (wb_valid && (wb_rd == rs1_q) && (wb_rd != '0)) ? wb_data : rf_rs1_dout;
    end
    if (rs2_use_q) begin
      op_rs2_d = (wb_valid && (wb_rd == rs2_q) && (wb_rd != '0)) ? wb_data : rf_rs2_dout;
    end
  end

  // Request sequencing: latch the request, issue the reads, capture the data, hold it for execute.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_use_q  <= 1'b0;
      rs2_use_q  <= 1'b0;
      op_valid_q <= 1'b0;
      op_rs1_q   <= '0;
      op_rs2_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            rs1_use_q <= req_rs1_use;
            rs2_use_q <= req_rs2_use;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!wb_valid) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          op_rs1_q   <= op_rs1_d;
          op_rs2_q   <= op_rs2_d;
          op_valid_q <= 1'b1;
          state_q    <= S_VALID;
        end
        S_VALID: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed bench for operand_fetch with a small register-file model.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic        req_rs1_use, req_rs2_use;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_rs1_data, op_rs2_data;
  logic        rf_rd_en, rf_rs1_en, rf_rs2_en;
  logic [4:0]  rf_rd, rf_rs1, rf_rs2;
  logic [31:0] rf_rd_din;
  logic [31:0] rf_rs1_dout, rf_rs2_dout;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  operand_fetch #(.reg_width(5), .data_width(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rs1_use(req_rs1_use), .req_rs2_use(req_rs2_use),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .rf_rd_en(rf_rd_en), .rf_rs1_en(rf_rs1_en), .rf_rs2_en(rf_rs2_en),
    .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rd_din(rf_rd_din),
    .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout),
    .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x0 reads as 0, reads are registered, rs2 is read only with rs1.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rf_rs1_dout <= '0;
      rf_rs2_dout <= '0;
    end else begin
      if (rf_rd_en && rf_rd != 5'd0) regs[rf_rd] <= rf_rd_din;
      if (rf_rs1_en) begin
        rf_rs1_dout <= regs[rf_rs1];
        if (rf_rs2_en) rf_rs2_dout <= regs[rf_rs2];
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    settle();
    check("wb_en", rf_rd_en, 1'b1);
    check("wb_rd", rf_rd, rd);
    check("wb_din", rf_rd_din, data);
    tick();
    wb_valid = 1'b0;
  endtask

  // Presents a request in IDLE and returns just after the accepting edge.
  task automatic accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2);
    req_valid   = 1'b1;
    req_rs1     = rs1;
    req_rs2     = rs2;
    req_rs1_use = u1;
    req_rs2_use = u2;
    settle();
    check("acc_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic release_op();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    settle();
    check("rel_valid", op_valid, 1'b0);
    check("rel_ready", req_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2;
    req_rs1_use = 1'b1; req_rs2_use = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA_AAAA; op_ready = 1'b0;

    // Reset held two cycles with request and writeback active
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rd_en", rf_rd_en, 1'b0);
    check("rst_rs1_en", rf_rs1_en, 1'b0);
    check("rst_op_valid", op_valid, 1'b0);
    check("rst_op_rs1", op_rs1_data, 32'h0);
    check("rst_op_rs2", op_rs2_data, 32'h0);
    rst_n = 1'b1; req_valid = 1'b0; wb_valid = 1'b0;
    settle();
    check("rel_req_ready", req_ready, 1'b1);

    // Write then read
    do_wb(5'd5, 32'hDEAD_BEEF);
    accept(5'd5, 5'd0, 1'b1, 1'b1);
    settle();
    check("wr_rs1_en", rf_rs1_en, 1'b1);
    check("wr_rs2_en", rf_rs2_en, 1'b1);
    check("wr_rf_rs1", rf_rs1, 5'd5);
    check("wr_rf_rs2", rf_rs2, 5'd0);
    check("wr_busy_ready", req_ready, 1'b0);
    tick();
    check("wr_c2_valid", op_valid, 1'b0);
    check("wr_c2_rf_rs1", rf_rs1, 5'd5);
    tick();
    check("wr_c3_valid", op_valid, 1'b1);
    check("wr_c3_rs1", op_rs1_data, 32'hDEAD_BEEF);
    check("wr_c3_rs2", op_rs2_data, 32'h0);
    release_op();

    // Write collision in ISSUE for two cycles
    accept(5'd3, 5'd4, 1'b1, 1'b1);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_0033;
    settle();
    check("col_c1_rs1_en", rf_rs1_en, 1'b0);
    check("col_c1_rs2_en", rf_rs2_en, 1'b0);
    check("col_c1_rd_en", rf_rd_en, 1'b1);
    tick();
    wb_rd = 5'd4; wb_data = 32'h0000_0044;
    settle();
    check("col_c2_rs1_en", rf_rs1_en, 1'b0);
    tick();
    wb_valid = 1'b0;
    settle();
    check("col_c3_rs1_en", rf_rs1_en, 1'b1);
    check("col_c3_rs2_en", rf_rs2_en, 1'b1);
    tick();
    check("col_c4_valid", op_valid, 1'b0);
    tick();
    check("col_c5_valid", op_valid, 1'b1);
    check("col_c5_rs1", op_rs1_data, 32'h0000_0033);
    check("col_c5_rs2", op_rs2_data, 32'h0000_0044);
    release_op();

    // WAIT bypass with a real destination
    do_wb(5'd7, 32'h0000_0001);
    accept(5'd7, 5'd7, 1'b1, 1'b1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0055;
    tick();
    wb_valid = 1'b0;
    settle();
    check("byp_rs1", op_rs1_data, 32'h0000_0055);
    check("byp_rs2", op_rs2_data, 32'h0000_0055);
    release_op();

    // Same with x0 destination: no forwarding
    do_wb(5'd7, 32'h0000_0001);
    accept(5'd7, 5'd7, 1'b1, 1'b1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_0099;
    settle();
    check("byp0_rd_en", rf_rd_en, 1'b1);
    check("byp0_rd", rf_rd, 5'd0);
    tick();
    wb_valid = 1'b0;
    settle();
    check("byp0_rs1", op_rs1_data, 32'h0000_0001);
    check("byp0_rs2", op_rs2_data, 32'h0000_0001);
    release_op();

    // rs2 only
    do_wb(5'd9, 32'h0000_1234);
    accept(5'd5, 5'd9, 1'b0, 1'b1);
    settle();
    check("r2o_rs1_en", rf_rs1_en, 1'b1);
    check("r2o_rs2_en", rf_rs2_en, 1'b1);
    tick();
    tick();
    check("r2o_valid", op_valid, 1'b1);
    check("r2o_rs1", op_rs1_data, 32'h0);
    check("r2o_rs2", op_rs2_data, 32'h0000_1234);
    release_op();

    // No operand used
    accept(5'd5, 5'd9, 1'b0, 1'b0);
    settle();
    check("none_rs1_en", rf_rs1_en, 1'b0);
    check("none_rs2_en", rf_rs2_en, 1'b0);
    tick();
    tick();
    check("none_valid", op_valid, 1'b1);
    check("none_rs1", op_rs1_data, 32'h0);
    check("none_rs2", op_rs2_data, 32'h0);
    release_op();

    // Backpressure with writebacks to the held register
    accept(5'd5, 5'd9, 1'b1, 1'b1);
    tick();
    tick();
    check("bp_valid", op_valid, 1'b1);
    check("bp_rs1", op_rs1_data, 32'hDEAD_BEEF);
    check("bp_rs2", op_rs2_data, 32'h0000_1234);
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_rd = (i % 2 == 0) ? 5'd5 : 5'd9; wb_data = 32'hC0DE_0000 + i;
      settle();
      check("bp_req_ready", req_ready, 1'b0);
      tick();
      check("bp_hold_valid", op_valid, 1'b1);
      check("bp_hold_rs1", op_rs1_data, 32'hDEAD_BEEF);
      check("bp_hold_rs2", op_rs2_data, 32'h0000_1234);
    end
    wb_valid = 1'b0; req_valid = 1'b0;
    release_op();

    // Reset while in WAIT
    accept(5'd5, 5'd9, 1'b1, 1'b1);
    tick();
    rst_n = 1'b0;
    settle();
    check("mr_rs1_en", rf_rs1_en, 1'b0);
    tick();
    check("mr_valid", op_valid, 1'b0);
    check("mr_req_ready", req_ready, 1'b0);
    check("mr_rs1_data", op_rs1_data, 32'h0);
    rst_n = 1'b1;
    settle();
    check("mr_rel_ready", req_ready, 1'b1);
    tick();
    check("mr_after_valid", op_valid, 1'b0);
    check("mr_after_ready", req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
